mc_control_fsm: RTL

Multicycle control unit for the RISC-V core. It sequences every instruction through fetch, decode, execute, memory and writeback steps, one state per clock. It drives the shared instruction/data memory's `memRead`/`memWrite` strobes and address select, the IR write enable, the PC write enable, and the datapath mux/ALU selects. It sits directly upstream of the unified memory and the datapath, and keeps a retired-instruction counter plus a sticky illegal-opcode trap.

---
 rtl/rv_ctrl_pkg.sv | 66 ++++++
 rtl/imm_src_dec.sv | 19 +
 rtl/mc_control_fsm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: state codes,
// opcodes, datapath mux selects and the Moore control word.
package rv_ctrl_pkg;

  localparam logic [3:0] S_RST      = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECR    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_ILLEGAL  = 4'd12;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  // Final step of every instruction: leaving it retires the instruction.
  function automatic logic retires(input logic [3:0] s);
    return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) || (s == S_BEQ);
  endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Opcode to immediate-format select for the immediate extender.
module imm_src_dec
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// counts retired instructions and traps on an illegal opcode.
module mc_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  output logic             memRead,
  output logic             memWrite,
  output logic             adrSrc,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             regWrite,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       resultSrc,
  output logic [1:0]       immSrc,
  output logic             trap,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             trap_q, trap_d;
  ctrl_t            ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_RST;
    endcase
  end

  // JAL also leaves through ALUWB, so it is counted exactly once there.
  always_comb begin
    retired_d = retired_q;
    if (retires(state_q)) retired_d = retired_q + CNT_W'(1);
    trap_d = trap_q | (state_d == S_ILLEGAL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RST;
      retired_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read   = 1'b1;
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.pc_update  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_read   = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MDR;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALU_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  imm_src_dec u_imm_src_dec (
    .opcode  (opcode),
    .imm_src (immSrc)
  );

  assign memRead   = ctrl.mem_read;
  assign memWrite  = ctrl.mem_write;
  assign adrSrc    = ctrl.adr_src;
  assign irWrite   = ctrl.ir_write;
  assign pcWrite   = ctrl.pc_update | (ctrl.branch & zero);
  assign regWrite  = ctrl.reg_write;
  assign aluSrcA   = ctrl.alu_src_a;
  assign aluSrcB   = ctrl.alu_src_b;
  assign aluOp     = ctrl.alu_op;
  assign resultSrc = ctrl.result_src;
  assign trap      = trap_q;
  assign retired   = retired_q;
  assign state     = state_q;

endmodule
